// File: rtl/dds_pwm_dac.sv
// -----------------------------------------------------------------------------
// dds_pwm_dac
//
// Converts a stream of DDS amplitude samples into a PWM bitstream that drives
// an external RC-filtered DAC. Samples arrive over a valid/ready handshake
// into a one-entry buffer. The buffer is transferred into the active duty
// register only at PWM period boundaries, so every period is produced with a
// single, consistent duty value.
//
// Parameters:
//   SAMPLE_BITS - sample and PWM counter width; one period = 2**SAMPLE_BITS ticks
//   PRESCALER   - clocks per PWM tick (1..65535); 1 means a tick every clock
//
// Ports:
//   Clock      - system clock, rising edge
//   Reset      - asynchronous active-low reset
//   Sample_i   - sample from the DDS
//   Valid_i    - Sample_i is valid
//   Ready_o    - input buffer empty; transfer on Valid_i && Ready_o
//   Pwm_o      - registered PWM output
//   Period_o   - one-clock pulse after each period boundary
//   Underrun_o - one-clock pulse when a boundary finds the buffer empty
//
// Optional build macro:
//   DDS_PWM_DAC_SIGNED_EN - when defined, Sample_i is two's complement and is
//                           converted to offset binary (MSB inverted) as it
//                           enters the buffer. Otherwise it is used unsigned.
// -----------------------------------------------------------------------------
module dds_pwm_dac #(
  parameter int SAMPLE_BITS = 8,
  parameter int PRESCALER   = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [SAMPLE_BITS-1:0] Sample_i,
  input  logic                   Valid_i,
  output logic                   Ready_o,
  output logic                   Pwm_o,
  output logic                   Period_o,
  output logic                   Underrun_o
);

  // Prescaler width; a PRESCALER of 1 still needs a 1-bit register.
  localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALER - 1);

  logic [PW-1:0]          presc_q,    presc_d;
  logic [SAMPLE_BITS-1:0] counter_q,  counter_d;
  logic [SAMPLE_BITS-1:0] duty_q,     duty_d;
  logic [SAMPLE_BITS-1:0] buf_q,      buf_d;
  logic                   buf_full_q, buf_full_d;
  logic                   ready_q;
  logic                   pwm_q;
  logic                   period_q;
  logic                   underrun_q;

  logic                   tick;
  logic                   boundary;
  logic                   load;
  logic [SAMPLE_BITS-1:0] sample_conv;

`ifdef DDS_PWM_DAC_SIGNED_EN
  // Two's complement to offset binary: 0 lands on mid-scale duty.
  assign sample_conv = {~Sample_i[SAMPLE_BITS-1], Sample_i[SAMPLE_BITS-2:0]};
`else
  assign sample_conv = Sample_i;
`endif

  assign tick     = (presc_q == PRESC_LAST);
  assign boundary = tick && (counter_q == {SAMPLE_BITS{1'b1}});
  // ready_q always mirrors !buf_full_q, so a load never meets a full buffer.
  assign load     = Valid_i && ready_q;

  always_comb begin
    presc_d    = presc_q;
    counter_d  = counter_q;
    duty_d     = duty_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;

    if (tick) begin
      presc_d   = '0;
      counter_d = counter_q + SAMPLE_BITS'(1);
    end else begin
      presc_d   = presc_q + PW'(1);
    end

    // Drain happens only with a full buffer and load only with an empty one,
    // so the two branches are mutually exclusive. A load coinciding with an
    // underrunning boundary fills the buffer but leaves the duty untouched.
    if (boundary && buf_full_q) begin
      duty_d     = buf_q;
      buf_full_d = 1'b0;
    end else if (load) begin
      buf_d      = sample_conv;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_q    <= '0;
      counter_q  <= '0;
      duty_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b1;
      pwm_q      <= 1'b0;
      period_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      counter_q  <= counter_d;
      duty_q     <= duty_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      ready_q    <= !buf_full_d;
      // Compare uses the pre-edge counter and duty: one clock of latency.
      pwm_q      <= (counter_q < duty_q);
      period_q   <= boundary;
      underrun_q <= boundary && !buf_full_q;
    end
  end

  assign Ready_o    = ready_q;
  assign Pwm_o      = pwm_q;
  assign Period_o   = period_q;
  assign Underrun_o = underrun_q;

endmodule

// File: tb/tb_dds_pwm_dac.sv
// -----------------------------------------------------------------------------
// Testbench for dds_pwm_dac. Two instances run side by side on one clock and
// one reset: lane 0 (PRESCALER=1) gets directed samples, lane 1 (PRESCALER=3)
// is fed duty 5 continuously. Each lane has a behavioural model that derives
// the outputs from elapsed clocks since reset, plus a per-cycle compare;
// directed per-period measurements pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_dds_pwm_dac;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid0 = 1'b0;
  logic       valid1 = 1'b0;
  logic [7:0] sample0 = 8'h00;
  logic [7:0] sample1 = 8'h00;
  logic [1:0] ready_w;
  logic [1:0] pwm_w;
  logic [1:0] period_w;
  logic [1:0] under_w;

  int checks = 0;
  int errors = 0;
  bit lane1_done = 1'b0;

  logic [7:0] send_q[$];

  initial forever #5 clk = ~clk;

  // Sample encoding so a requested duty d gives duty d in either build.
  function automatic logic [7:0] enc(input int d);
`ifdef DDS_PWM_DAC_SIGNED_EN
    enc = 8'(d) ^ 8'h80;
`else
    enc = 8'(d);
`endif
  endfunction

  // Duty that a raw input sample must produce.
  function automatic int to_duty(input logic [7:0] s);
`ifdef DDS_PWM_DAC_SIGNED_EN
    to_duty = int'($signed(s)) + 128;
`else
    to_duty = int'(s);
`endif
  endfunction

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int P = (gi == 0) ? 1 : 3;

    dds_pwm_dac #(
      .SAMPLE_BITS(8),
      .PRESCALER  (P)
    ) u_dut (
      .Clock     (clk),
      .Reset     (rst_n),
      .Sample_i  ((gi == 0) ? sample0 : sample1),
      .Valid_i   ((gi == 0) ? valid0 : valid1),
      .Ready_o   (ready_w[gi]),
      .Pwm_o     (pwm_w[gi]),
      .Period_o  (period_w[gi]),
      .Underrun_o(under_w[gi])
    );

    // Model: k = rising edges since reset release. Before edge k the tick
    // counter reads floor(k/P) mod 256, and edge k is a period boundary when
    // k mod 256P == 256P-1. Buffer is a queue holding at most one sample.
    int         k;
    int         duty;
    int         q[$];
    logic [3:0] exp_v;   // {pwm, period, underrun, ready}

    initial begin
      k = 0;
      duty = 0;
      exp_v = 4'b0001;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          k = 0;
          duty = 0;
          q.delete();
          exp_v = 4'b0001;
        end else begin
          bit   bnd;
          bit   v;
          logic [7:0] s;
          v = (gi == 0) ? valid0 : valid1;
          s = (gi == 0) ? sample0 : sample1;
          bnd = ((k % (256 * P)) == (256 * P - 1));
          exp_v[3] = (((k / P) % 256) < duty);
          exp_v[2] = bnd;
          exp_v[1] = bnd && (q.size() == 0);
          if (bnd && q.size() != 0) duty = q.pop_front();
          else if (v && q.size() == 0) q.push_back(to_duty(s));
          exp_v[0] = (q.size() == 0);
          k++;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      checks++;
      if ({pwm_w[gi], period_w[gi], under_w[gi], ready_w[gi]} !== exp_v) begin
        errors++;
        $display("FAIL lane%0d_outputs t=%0t: got pwm/period/under/ready=%b required %b",
                 gi, $time, {pwm_w[gi], period_w[gi], under_w[gi], ready_w[gi]}, exp_v);
      end
    end
  end

  // Lane 0 driver: presents the head of send_q; a word is consumed when
  // valid and ready were both high across the preceding rising edge.
  initial begin
    bit rdy_seen;
    rdy_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && valid0 && rdy_seen && send_q.size() != 0) void'(send_q.pop_front());
      if (send_q.size() != 0) begin
        valid0  = 1'b1;
        sample0 = send_q[0];
      end else begin
        valid0  = 1'b0;
      end
      rdy_seen = ready_w[0];
    end
  end

  // Counts lane-0 clocks and high clocks up to and including the next
  // Period_o pulse; that window spans counter values 0..255 of one period.
  task automatic wait_pulse(output int cyc, output int hi, output int und);
    cyc = 0;
    hi  = 0;
    und = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (pwm_w[0]) hi++;
      if (period_w[0]) begin
        und = int'(under_w[0]);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL period_timeout: got no Period_o pulse in 2000 clocks required one");
  endtask

  task automatic period_check(input string tag, input int req_hi, input int req_und);
    int cyc, hi, und;
    wait_pulse(cyc, hi, und);
    $display("period %s: clocks=%0d high=%0d underrun=%0d", tag, cyc, hi, und);
    check({tag, "_len"}, cyc, 256);
    check({tag, "_high"}, hi, req_hi);
    check({tag, "_underrun"}, und, req_und);
  endtask

  // Lane 1: PRESCALER=3 with duty 5 -> 768-clock period, 15 high clocks.
  initial begin
    int  cyc, hi, pulses;
    bit  to;
    wait (rst_n === 1'b0);
    wait (rst_n === 1'b1);
    pulses = 0;
    cyc = 0;
    hi = 0;
    to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (pulses == 2) begin
        cyc++;
        if (pwm_w[1]) hi++;
      end
      if (period_w[1]) begin
        pulses++;
        if (pulses == 3) begin
          to = 1'b0;
          break;
        end
      end
    end
    if (to) begin
      checks++;
      errors++;
      $display("FAIL lane1_timeout: got %0d Period_o pulses required 3", pulses);
    end else begin
      $display("period lane1: clocks=%0d high=%0d", cyc, hi);
      check("lane1_len", cyc, 768);
      check("lane1_high", hi, 15);
    end
    lane1_done = 1'b1;
  end

  initial begin
    valid1  = 1'b1;
    sample1 = enc(5);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    check("release_ready", int'(ready_w[0]), 1);
    check("release_pwm", int'(pwm_w[0]), 0);

    // Idle first period: low throughout, underrun at its end.
    period_check("idle", 0, 1);

    // Handshake: 10 buffered, 20 held upstream until the next boundary.
    send_q.push_back(enc(10));
    send_q.push_back(enc(20));
    period_check("load10", 0, 0);
    period_check("duty10", 10, 0);
    period_check("duty20", 20, 1);
    period_check("hold20", 20, 1);

    // Continuous duty 64.
    repeat (4) send_q.push_back(enc(64));
    period_check("to64", 20, 0);
    period_check("duty64a", 64, 0);
    period_check("duty64b", 64, 0);
    period_check("duty64c", 64, 0);

    // Maximum duty 255, then zero duty.
    send_q.push_back(enc(255));
    period_check("duty64d", 64, 0);
    period_check("duty255", 255, 1);
    send_q.push_back(enc(0));
    period_check("to0", 255, 0);
    period_check("duty0", 0, 1);

    // Reset mid-period with duty 100 active and the buffer full.
    send_q.push_back(enc(100));
    send_q.push_back(enc(100));
    period_check("to100", 0, 0);
    repeat (50) @(negedge clk);
    check("mid100_pwm", int'(pwm_w[0]), 1);
    check("mid100_ready", int'(ready_w[0]), 0);
    #2 rst_n = 1'b0;
    send_q.delete();
    #1;
    check("async_ready", int'(ready_w[0]), 1);
    check("async_pwm", int'(pwm_w[0]), 0);
    check("async_period", int'(period_w[0]), 0);
    check("async_underrun", int'(under_w[0]), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    period_check("after_reset", 0, 1);

`ifdef DDS_PWM_DAC_SIGNED_EN
    // Raw two's complement inputs: 0x00 -> 128, 0x80 -> 0, 0x7F -> 255.
    send_q.push_back(8'h00);
    send_q.push_back(8'h80);
    send_q.push_back(8'h7F);
    period_check("s_load", 0, 0);
    period_check("s_zero", 128, 0);
    period_check("s_min", 0, 0);
    period_check("s_max", 255, 1);
`endif

    check("lane1_done", int'(lane1_done), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
